// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   localparam logic [31:0] DATA_OFS   = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;

   localparam int unsigned STAT_FULL   = 0;
   localparam int unsigned STAT_EMPTY  = 1;
   localparam int unsigned STAT_BUSY   = 2;
   localparam int unsigned STAT_PARITY = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide TX FIFO; head entry is visible combinationally on dout_o.
// A push is accepted when full only if a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
   end

   logic [7:0]     mem_q [DEPTH];
   logic [AddrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic           do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
   assign dout_o  = mem_q[rptr_q[AddrW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q[AddrW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA writes feed a TX FIFO, frames leave LSB-first on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 1_000_000,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  dbus_en_i,
   input  logic [31:0] dbus_write_addr_i,
   input  logic [31:0] dbus_write_data_i,
   input  logic [31:0] dbus_read_addr_i,
   output logic [31:0] dbus_read_data_o,
   output logic        tx_o
);

   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
   localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
   localparam logic [31:0] DataAddr   = BASE_ADDR + DATA_OFS;
   localparam logic [31:0] StatusAddr = BASE_ADDR + STATUS_OFS;

   if (ClksPerBit < 2) begin : g_cpb_check
      $error("uart_tx_mmio: CLK_FREQ/BAUD must be >= 2");
   end

   tx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     status;
   logic            bit_done, busy;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]      fifo_dout;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   logic unused_bus;
   assign unused_bus = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

   assign fifo_push = dbus_en_i[0] && (dbus_write_addr_i == DataAddr);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (dbus_write_data_i[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         rdata_q   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         rdata_q   <= rdata_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bit_done = (cnt_q == CntMax);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q != StIdle) begin
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = StStart;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^fifo_dout;
`endif
            end
         end
         StStart: if (bit_done) state_d = StData;
         StData: begin
            if (bit_done) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
         StParity: if (bit_done) state_d = StStop;
         StStop:   if (bit_done) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Line level is computed from the next state so tx_o comes straight from a flop.
   always_comb begin
      tx_d = 1'b1;
      busy = (state_q != StIdle);
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      status             = '0;
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_BUSY]  = busy;
`ifdef UART_TX_PARITY_EN
      status[STAT_PARITY] = 1'b1;
`endif
      rdata_d = (dbus_read_addr_i == StatusAddr) ? status : '0;
   end

   assign dbus_read_data_o = rdata_q;
   assign tx_o             = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: bus writes queue expected bytes, a line receiver decodes tx_o.
module tb_uart_tx_mmio;

   localparam int unsigned CPB       = 100;
   localparam logic [31:0] BASE      = 32'h4000_0000;
   localparam logic [31:0] STAT_ADDR = 32'h4000_0004;
   localparam logic [31:0] EXIT_ADDR = 32'h4000_8000;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
   localparam logic [31:0] ST_PAR     = 32'h8;
`else
   localparam int unsigned FRAME_BITS = 10;
   localparam logic [31:0] ST_PAR     = 32'h0;
`endif
   localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;
   localparam int unsigned TIMEOUT   = 3 * FRAME_CYC;

   typedef struct {
      logic [7:0]  data;
      bit          ok;
      int unsigned start;
   } rx_rec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  dbus_en;
   logic [31:0] dbus_waddr, dbus_wdata, dbus_raddr, dbus_rdata;
   logic        tx;

   int unsigned cyc = 0;
   int unsigned rst_count = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   rx_rec_t     rx_q[$];

   uart_tx_mmio #(
      .CLK_FREQ   (100_000_000),
      .BAUD       (1_000_000),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (16)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .dbus_en_i         (dbus_en),
      .dbus_write_addr_i (dbus_waddr),
      .dbus_write_data_i (dbus_wdata),
      .dbus_read_addr_i  (dbus_raddr),
      .dbus_read_data_o  (dbus_rdata),
      .tx_o              (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_count <= rst_count + 1;

   // Line receiver: samples each bit mid-period; frames cut by a reset are discarded.
   initial begin : rx_monitor
      logic        prev;
      logic [7:0]  d;
      bit          ok;
      int unsigned rc, st;
      rx_rec_t     r;
      prev = 1'b1;
      d    = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
            st = cyc;
            rc = rst_count;
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               d[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            if (tx !== ^d) ok = 1'b0;
`endif
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
            r.data  = d;
            r.ok    = ok;
            r.start = st;
            if (rc == rst_count && rst_n === 1'b1) rx_q.push_back(r);
            prev = 1'b1;
         end else begin
            prev = tx;
         end
      end
   end

   task automatic bus_write(input logic [31:0] addr, input logic [7:0] data,
                            input logic [3:0] en, input bit expect_frame,
                            output int unsigned wcyc);
      @(negedge clk);
      dbus_waddr = addr;
      dbus_wdata = {24'hDEAD_BE, data};
      dbus_en    = en;
      wcyc       = cyc;
      if (expect_frame) exp_q.push_back(data);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      dbus_en = 4'b0000;
   endtask

   task automatic read_reg(input logic [31:0] addr, output logic [31:0] v);
      @(negedge clk);
      dbus_raddr = addr;
      @(negedge clk);
      v = dbus_rdata;
   endtask

   task automatic get_frame(output rx_rec_t r, output bit got);
      got = 1'b0;
      r.data = '0;
      r.ok = 1'b0;
      r.start = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic count_low(input int unsigned n, output int unsigned bad);
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      int unsigned bad;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || dbus_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b rdata=%h, expected tx=1 rdata=0", tx, dbus_rdata);
      end
      rst_n = 1'b1;
      count_low(50, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_line: %0d low cycles, expected 0", bad);
      end
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h2 | ST_PAR)) begin
         errors++;
         $display("FAIL idle_status: got %h, expected %h", v, 32'h2 | ST_PAR);
      end
      read_reg(BASE, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL data_reg_read: got %h, expected 0", v);
      end
   endtask

   task automatic test_single();
      int unsigned n;
      rx_rec_t r;
      bit got;
      logic [31:0] v;
      logic [7:0] e;
      bus_write(BASE, 8'h55, 4'b0001, 1'b1, n);
      bus_idle();
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h6 | ST_PAR)) begin
         errors++;
         $display("FAIL busy_status: got %h, expected %h", v, 32'h6 | ST_PAR);
      end
      get_frame(r, got);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (!got || r.data !== e || !r.ok) begin
         errors++;
         $display("FAIL single_frame: got=%0b data=%h ok=%0b, expected data=%h ok=1",
                  got, r.data, r.ok, e);
      end
      checks++;
      if (r.start !== n + 2) begin
         errors++;
         $display("FAIL start_latency: start cycle %0d, expected %0d", r.start, n + 2);
      end
      repeat (CPB) @(negedge clk);
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h2 | ST_PAR)) begin
         errors++;
         $display("FAIL busy_clear: got %h, expected %h", v, 32'h2 | ST_PAR);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned n, bad;
      rx_rec_t r;
      bit got;
      logic [31:0] v;
      logic [7:0] e;
      for (int i = 0; i < 18; i++) begin
         bus_write(BASE, 8'(8'h10 + i), 4'b0001, i < 17, n);
      end
      bus_idle();
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h5 | ST_PAR)) begin
         errors++;
         $display("FAIL full_status: got %h, expected %h", v, 32'h5 | ST_PAR);
      end
      for (int i = 0; i < 17; i++) begin
         get_frame(r, got);
         e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (!got || r.data !== e || !r.ok) begin
            errors++;
            $display("FAIL burst_frame_%0d: got=%0b data=%h ok=%0b, expected data=%h",
                     i, got, r.data, r.ok, e);
         end
      end
      count_low(2 * FRAME_CYC, bad);
      checks++;
      if (rx_q.size() !== 0) begin
         errors++;
         $display("FAIL dropped_write: %0d extra frames, expected 0", rx_q.size());
      end
   endtask

   task automatic test_gap();
      int unsigned n;
      rx_rec_t r1, r2;
      bit got1, got2;
      logic [7:0] e1, e2;
      bus_write(BASE, 8'h41, 4'b0001, 1'b1, n);
      bus_write(BASE, 8'h42, 4'b0001, 1'b1, n);
      bus_idle();
      get_frame(r1, got1);
      get_frame(r2, got2);
      e1 = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      e2 = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (!got1 || !got2 || r1.data !== e1 || r2.data !== e2 || !r1.ok || !r2.ok) begin
         errors++;
         $display("FAIL ab_frames: got %h %h, expected %h %h", r1.data, r2.data, e1, e2);
      end
      checks++;
      if (r2.start - r1.start !== FRAME_CYC + 1) begin
         errors++;
         $display("FAIL frame_gap: spacing %0d, expected %0d",
                  r2.start - r1.start, FRAME_CYC + 1);
      end
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int unsigned n, bad;
      logic [31:0] v;
      dbus_raddr = STAT_ADDR;
      bus_write(BASE, 8'hFF, 4'b0001, 1'b1, n);
      bus_idle();
      repeat (4 * CPB) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || dbus_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_data: tx=%b rdata=%h, expected 1 and 0", tx, dbus_rdata);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h2 | ST_PAR)) begin
         errors++;
         $display("FAIL post_reset_status: got %h, expected %h", v, 32'h2 | ST_PAR);
      end
      // Second abort lands in the start bit, where the line is low.
      bus_write(BASE, 8'h00, 4'b0001, 1'b1, n);
      bus_idle();
      repeat (CPB / 2) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL start_bit_low: tx=%b, expected 0", tx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_async_start: tx=%b, expected 1", tx);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_low(2 * FRAME_CYC, bad);
      checks++;
      if (bad !== 0 || rx_q.size() !== 0) begin
         errors++;
         $display("FAIL no_resume: %0d low cycles, %0d frames, expected 0 and 0",
                  bad, rx_q.size());
      end
   endtask

   task automatic test_ignored_writes();
      int unsigned n, bad;
      logic [31:0] v;
      bus_write(BASE, 8'hA5, 4'b1110, 1'b0, n);
      bus_write(EXIT_ADDR, 8'h3C, 4'b1111, 1'b0, n);
      bus_write(STAT_ADDR, 8'h77, 4'b1111, 1'b0, n);
      bus_idle();
      count_low(3 * CPB, bad);
      checks++;
      if (bad !== 0 || rx_q.size() !== 0) begin
         errors++;
         $display("FAIL ignored_writes: %0d low cycles, %0d frames, expected 0 and 0",
                  bad, rx_q.size());
      end
      read_reg(STAT_ADDR, v);
      checks++;
      if (v !== (32'h2 | ST_PAR)) begin
         errors++;
         $display("FAIL ignored_status: got %h, expected %h", v, 32'h2 | ST_PAR);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      dbus_en    = 4'b0000;
      dbus_waddr = '0;
      dbus_wdata = '0;
      dbus_raddr = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_mid_reset();
      test_ignored_writes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
